// File: rtl/seg7_counter_display_if.sv
// seg7_counter_display_if: control, load and display bundle between the
// board switches/keys, the counter and the HEX displays.
interface seg7_counter_display_if #(
   parameter int DIGITS = 4
);
   logic                enable, up, decimal, blank_lz, load;
   logic [4*DIGITS-1:0] load_value, value;
   logic [7*DIGITS-1:0] HEX;
   logic                wrap;
   modport master (
      output enable, up, decimal, blank_lz, load, load_value,
      input  HEX, wrap, value
   );
   modport slave (
      input  enable, up, decimal, blank_lz, load, load_value,
      output HEX, wrap, value
   );
endinterface

// File: rtl/seg7_counter_display.sv
// seg7_counter_display: prescaled multi-digit hex/BCD up/down counter driving
// registered active-low seven-segment digits with leading-zero blanking.
module seg7_counter_display #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000000
) (
   input logic                   CLOCK_50,
   input logic                   resetn,
   seg7_counter_display_if.slave bus
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [6:0] SEG [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] r_value, w_step, w_load;
   logic [7*DIGITS-1:0] r_hex, w_hex;
   logic                r_wrap_p, r_wrap, w_tick, w_carry, w_lead;
   logic [3:0]          w_d, w_max;
   assign w_tick = r_presc == PW'(TICK_DIV - 1);
   // Ripple the carry/borrow from digit 0 upward; a carry out of the top digit is a wrap.
   always_comb begin
      w_carry = 1'b1;
      w_step  = r_value;
      w_load  = bus.load_value;
      w_d     = 4'd0;
      w_max   = bus.decimal ? 4'd9 : 4'hF;
      for (int k = 0; k < DIGITS; k++) begin
         w_d = bus.decimal && r_value[4*k +: 4] > 4'd9 ? 4'd9 : r_value[4*k +: 4];
         w_step[4*k +: 4] = !w_carry ? w_d :
                            bus.up ? (w_d == w_max ? 4'd0 : w_d + 4'd1) :
                                     (w_d == 4'd0 ? w_max : w_d - 4'd1);
         w_carry = w_carry && w_d == (bus.up ? w_max : 4'd0);
         w_load[4*k +: 4] = bus.decimal && bus.load_value[4*k +: 4] > 4'd9 ? 4'd9 : bus.load_value[4*k +: 4];
      end
   end
   // Scan from the top digit so w_lead tracks "this and all higher digits are zero".
   always_comb begin
      w_lead = 1'b1;
      w_hex  = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_lead = w_lead && r_value[4*k +: 4] == 4'd0;
         w_hex[7*k +: 7] = bus.blank_lz && w_lead && k > 0 ? 7'h7F : SEG[r_value[4*k +: 4]];
      end
   end
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_presc  <= '0;
         r_value  <= '0;
         r_hex    <= {DIGITS{7'b1000000}};
         r_wrap_p <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_presc  <= bus.load || w_tick ? '0 : r_presc + PW'(1);
         r_value  <= bus.load ? w_load : w_tick && bus.enable ? w_step : r_value;
         r_wrap_p <= !bus.load && w_tick && bus.enable && w_carry;
         r_wrap   <= r_wrap_p;
         r_hex    <= w_hex;
      end
   end
   assign bus.value = r_value;
   assign bus.HEX   = r_hex;
   assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_seg7_counter_display.sv
// tb_seg7_counter_display: directed scenarios for a 2-digit, divide-by-4 counter,
// checked every cycle against an integer-arithmetic model of the counter.
module tb_seg7_counter_display;
   localparam logic [6:0] GLYPH [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [13:0] ZERO = {2{7'b1000000}};
   logic clk = 1'b0, resetn = 1'b0;
   always #5 clk = ~clk;
   seg7_counter_display_if #(.DIGITS(2)) bus ();
   seg7_counter_display #(.DIGITS(2), .TICK_DIV(4)) dut (.CLOCK_50(clk), .resetn(resetn), .bus(bus));
   int n_chk = 0, n_fail = 0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [13:0] show(logic [7:0] v, logic blz);
      show = {blz && v[7:4] == 4'd0 ? 7'h7F : GLYPH[v[7:4]], GLYPH[v[3:0]]};
   endfunction
   function automatic logic [7:0] sat(logic [7:0] v, logic dm);
      sat = {dm && v[7:4] > 9 ? 4'd9 : v[7:4], dm && v[3:0] > 9 ? 4'd9 : v[3:0]};
   endfunction
   // Returns {wrap, next value}: the display treated as one base-10/16 number, modulo base^2.
   function automatic logic [8:0] next_val(logic [7:0] v, logic dm, logic upd);
      int b, t, hi, lo, n;
      b  = dm ? 10 : 16;
      t  = b * b;
      hi = v[7:4] > b - 1 ? b - 1 : int'(v[7:4]);
      lo = v[3:0] > b - 1 ? b - 1 : int'(v[3:0]);
      n  = (hi * b + lo + (upd ? 1 : -1) + t) % t;
      next_val = {upd ? n == 0 : n == t - 1, 8'(n / b * 16 + n % b)};
   endfunction
   logic [7:0]  m_val = 8'h00;
   logic [13:0] m_hex = ZERO;
   logic        m_wrap = 1'b0, m_pend = 1'b0;
   int          m_presc = 0;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_val = 8'h00; m_presc = 0; m_hex = ZERO; m_wrap = 1'b0; m_pend = 1'b0;
      end else begin
         m_hex  = show(m_val, bus.blank_lz);
         m_wrap = m_pend;
         m_pend = 1'b0;
         if (bus.load) begin
            m_val   = sat(bus.load_value, bus.decimal);
            m_presc = 0;
         end else begin
            if (m_presc == 3 && bus.enable) {m_pend, m_val} = next_val(m_val, bus.decimal, bus.up);
            m_presc = (m_presc + 1) % 4;
         end
      end
   end
   always @(negedge clk) begin
      chk("value", bus.value, m_val);
      chk("hex", bus.HEX, m_hex);
      chk("wrap", bus.wrap, m_wrap);
   end
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_load(logic [7:0] v);
      bus.load = 1'b1; bus.load_value = v;
      cyc(1);
      bus.load = 1'b0;
   endtask
   initial begin
      {bus.enable, bus.up, bus.decimal, bus.blank_lz, bus.load} = '0;
      bus.load_value = 8'h00;
      cyc(2);
      chk("rst_value", bus.value, 0); chk("rst_hex", bus.HEX, ZERO); chk("rst_wrap", bus.wrap, 0);
      resetn = 1'b1; bus.enable = 1'b1; bus.up = 1'b1;
      cyc(3); chk("pre_tick", bus.value, 0);
      cyc(1); chk("first_tick", bus.value, 1);
      do_load(8'hFE); chk("load_fe", bus.value, 8'hFE);
      cyc(4); chk("up_ff", bus.value, 8'hFF); chk("hex_f", bus.HEX[13:7], 7'b0001110);
      cyc(4); chk("up_wrap", bus.value, 0); chk("wrap_early", bus.wrap, 0);
      cyc(1); chk("wrap_pulse", bus.wrap, 1); chk("hex_00", bus.HEX, ZERO);
      cyc(1); chk("wrap_end", bus.wrap, 0);
      bus.decimal = 1'b1; bus.up = 1'b0;
      do_load(8'h10); chk("load_10", bus.value, 8'h10);
      cyc(4); chk("dn_09", bus.value, 8'h09);
      cyc(4); chk("dn_08", bus.value, 8'h08);
      do_load(8'h00);
      cyc(4); chk("dn_99", bus.value, 8'h99);
      cyc(1); chk("wrap_99", bus.wrap, 1);
      do_load(8'hAC); chk("sat_99", bus.value, 8'h99);
      cyc(3);
      do_load(8'h42); chk("collide_42", bus.value, 8'h42);
      cyc(3); chk("collide_hold", bus.value, 8'h42);
      cyc(1); chk("collide_step", bus.value, 8'h41);
      bus.enable = 1'b0; bus.decimal = 1'b0; bus.blank_lz = 1'b1;
      do_load(8'h05);
      cyc(1); chk("blank_05", bus.HEX, {7'h7F, 7'b0010010});
      bus.blank_lz = 1'b0;
      cyc(1); chk("noblank_05", bus.HEX[13:7], 7'b1000000);
      bus.blank_lz = 1'b1;
      do_load(8'h00);
      cyc(1); chk("blank_00", bus.HEX, {7'h7F, 7'b1000000});
      do_load(8'h0B);
      bus.decimal = 1'b1; bus.up = 1'b1; bus.enable = 1'b1;
      cyc(3); chk("mode_hold", bus.value, 8'h0B);
      cyc(1); chk("mode_10", bus.value, 8'h10);
      cyc(1); chk("mode_hex", bus.HEX, {7'b1111001, 7'b1000000});
      cyc(2);
      #2 resetn = 1'b0;
      #1;
      chk("arst_value", bus.value, 0); chk("arst_hex", bus.HEX, ZERO); chk("arst_wrap", bus.wrap, 0);
      @(negedge clk);
      resetn = 1'b1;
      cyc(3); chk("post_rst_hold", bus.value, 0);
      cyc(2); chk("post_rst_step", bus.value, 1); chk("post_rst_hex", bus.HEX, {7'h7F, 7'b1111001});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
